counter_timer_arbiter: RTL and testbench

- Shares one CW-bit up-count engine among NREQ requesters.
- Each requester asks for an interval of len ticks. The block grants the engine round-robin, counts the interval, and pulses done to the owner.
- Sits between the counter datapath and client FSMs that need timed waits, so those clients do not each instantiate their own counter.

---
 rtl/counter_timer_arbiter.sv | 130 +++++++++++++
 tb/tb_counter_timer_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_arbiter.sv
// rtl/counter_timer_arbiter.sv - round-robin arbiter sharing one interval counter among NREQ clients
// Optional TIMER_ABORT_EN: withdrawing req[owner] during RUN aborts the interval and pulses abort.
module counter_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CW-1:0]       len,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [CW-1:0]            count,
`ifdef TIMER_ABORT_EN
  output logic                     abort,
`endif
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_n;
  logic [OW-1:0]   ptr, ptr_n;
  logic [OW-1:0]   owner_n;
  logic [CW-1:0]   len_q, len_n;
  logic [CW-1:0]   count_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic [OW-1:0]   sel, cand;
  logic            found;
`ifdef TIMER_ABORT_EN
  logic            abort_n;
`endif

  // First requester strictly after the last grantee, wrapping, so the last owner ranks lowest.
  always_comb begin
    sel   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ptr   <= OW'(NREQ - 1);
      owner <= '0;
      len_q <= '0;
      count <= '0;
      gnt   <= '0;
      done  <= '0;
`ifdef TIMER_ABORT_EN
      abort <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      len_q <= len_n;
      count <= count_n;
      gnt   <= gnt_n;
      done  <= done_n;
`ifdef TIMER_ABORT_EN
      abort <= abort_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (found) state_n = S_RUN;
      S_RUN: begin
`ifdef TIMER_ABORT_EN
        if (!req[owner]) state_n = S_IDLE;
        else
`endif
        if (count == len_q) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_n   = ptr;
    owner_n = owner;
    len_n   = len_q;
    count_n = count;
    gnt_n   = '0;
    done_n  = '0;
`ifdef TIMER_ABORT_EN
    abort_n = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_n   = NREQ'(1) << sel;
          owner_n = sel;
          ptr_n   = sel;
          len_n   = len[int'(sel)*CW +: CW];
          count_n = '0;
        end
      end
      S_RUN: begin
`ifdef TIMER_ABORT_EN
        if (!req[owner]) abort_n = 1'b1;
        else
`endif
        if (count == len_q) done_n = NREQ'(1) << owner;
        else begin
          gnt_n   = NREQ'(1) << owner;
          count_n = count + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// tb/tb_counter_timer_arbiter.sv - scoreboard bench for counter_timer_arbiter
module tb_counter_timer_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] len = '0;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [3:0]  count;
  logic [1:0]  owner;
`ifdef TIMER_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {int idx; int w; bit ok; int gap;} ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t cur;
  int  idle_run = 0;
  logic [3:0] prev_g = '0;

  counter_timer_arbiter #(.NREQ(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .gnt(gnt), .done(done),
    .busy(busy), .count(count),
`ifdef TIMER_ABORT_EN
    .abort(abort),
`endif
    .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Collect completed grants: owner, gnt width, count sequence and idle gap before the grant.
  always @(negedge clk) begin
    if (!rst) begin
      prev_g   = '0;
      idle_run = 0;
    end else begin
      if (gnt != 0) begin
        if (prev_g == 0) begin
          cur.idx = oh2i(gnt);
          cur.w   = 0;
          cur.ok  = 1'b1;
          cur.gap = idle_run;
        end
        if (int'(count) != cur.w) cur.ok = 1'b0;
        if (gnt != (4'b0001 << cur.idx)) cur.ok = 1'b0;
        cur.w++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (done != 0) begin
        if (done != (4'b0001 << cur.idx) || gnt != 0) cur.ok = 1'b0;
        obs_q.push_back(cur);
      end
      prev_g = gnt;
    end
  end

  task automatic wait_obs(input int n, output bit to);
    int c = 0;
    while (obs_q.size() < n && c < 300) begin
      @(negedge clk); #1;
      c++;
    end
    to = (obs_q.size() < n);
  endtask

  task automatic wait_count(input int v, input logic [3:0] g, output bit to);
    int c = 0;
    while (!(int'(count) == v && gnt == g) && c < 300) begin
      @(negedge clk); #1;
      c++;
    end
    to = !(int'(count) == v && gnt == g);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0)   begin failures++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    checks++; if (done !== 4'b0)  begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (count !== 4'b0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (owner !== 2'b0) begin failures++; $display("FAIL reset_owner got=%0d want=0", owner); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_single();
    bit to;
    ev_t e, o;
    req = 4'b0001;
    len = 16'h0003;
    exp_q.push_back('{0, 4, 1'b1, 0});
    wait_obs(1, to);
    req = '0;
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=no_done want=done"); end
    @(negedge clk); #1;
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL single_done_width got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_low got=%b want=0", busy); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.w !== e.w || o.ok !== 1'b1) begin
        failures++; $display("FAIL single_grant got=idx%0d w%0d ok%0d want=idx%0d w%0d", o.idx, o.w, o.ok, e.idx, e.w);
      end
    end
  endtask

  task automatic test_zero_len();
    bit to;
    ev_t e, o;
    req = 4'b0100;
    len = 16'h0000;
    exp_q.push_back('{2, 1, 1'b1, 0});
    wait_obs(1, to);
    req = '0;
    checks++; if (to) begin failures++; $display("FAIL zero_timeout got=no_done want=done"); end
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL zero_owner got=%0d want=2", owner); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.w !== e.w || o.ok !== 1'b1) begin
        failures++; $display("FAIL zero_grant got=idx%0d w%0d ok%0d want=idx%0d w%0d", o.idx, o.w, o.ok, e.idx, e.w);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_round_robin();
    bit to;
    ev_t e, o;
    int k = 0;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    req = 4'b1111;
    len = 16'h1111;
    foreach (order[i]) exp_q.push_back('{order[i], 2, 1'b1, 2});
    wait_obs(6, to);
    req = '0;
    checks++; if (to) begin failures++; $display("FAIL rr_timeout got=%0d want=6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.w !== e.w || o.ok !== 1'b1 || (k > 0 && o.gap !== e.gap)) begin
        failures++; $display("FAIL rr_grant%0d got=idx%0d w%0d gap%0d ok%0d want=idx%0d w%0d gap%0d", k, o.idx, o.w, o.gap, o.ok, e.idx, e.w, e.gap);
      end
      k++;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_late_arrival();
    bit to;
    ev_t e, o;
    req = 4'b0001;
    len = 16'h0005;
    exp_q.push_back('{0, 6, 1'b1, 0});
    exp_q.push_back('{1, 3, 1'b1, 0});
    wait_count(2, 4'b0001, to);
    checks++; if (to) begin failures++; $display("FAIL late_count2 got=%0d want=2", count); end
    req = 4'b0011;
    len = 16'h0021;
    wait_obs(1, to);
    req = 4'b0010;
    wait_obs(2, to);
    req = '0;
    checks++; if (to) begin failures++; $display("FAIL late_timeout got=%0d want=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.w !== e.w || o.ok !== 1'b1) begin
        failures++; $display("FAIL late_grant got=idx%0d w%0d ok%0d want=idx%0d w%0d", o.idx, o.w, o.ok, e.idx, e.w);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit to;
    ev_t e, o;
    req = 4'b1000;
    len = 16'hF000;
    wait_count(7, 4'b1000, to);
    checks++; if (to) begin failures++; $display("FAIL mid_count7 got=%0d want=7", count); end
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0)   begin failures++; $display("FAIL mid_gnt got=%b want=0", gnt); end
    checks++; if (done !== 4'b0)  begin failures++; $display("FAIL mid_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL mid_busy got=%b want=0", busy); end
    checks++; if (count !== 4'b0) begin failures++; $display("FAIL mid_count got=%0d want=0", count); end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL mid_no_done got=%0d want=0", obs_q.size()); end
    exp_q.push_back('{3, 16, 1'b1, 0});
    wait_obs(1, to);
    req = '0;
    checks++; if (to) begin failures++; $display("FAIL mid_regrant_timeout got=no_done want=done"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.w !== e.w || o.ok !== 1'b1) begin
        failures++; $display("FAIL mid_regrant got=idx%0d w%0d ok%0d want=idx%0d w%0d", o.idx, o.w, o.ok, e.idx, e.w);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_withdraw();
    bit to;
    ev_t e, o;
    req = 4'b0010;
    len = 16'h00A2;
    wait_count(4, 4'b0010, to);
    checks++; if (to) begin failures++; $display("FAIL wd_count4 got=%0d want=4", count); end
    req = 4'b0001;
`ifdef TIMER_ABORT_EN
    @(negedge clk); #1;
    checks++; if (gnt !== 4'b0)   begin failures++; $display("FAIL abort_gnt got=%b want=0", gnt); end
    checks++; if (abort !== 1'b1) begin failures++; $display("FAIL abort_flag got=%b want=1", abort); end
    checks++; if (done !== 4'b0)  begin failures++; $display("FAIL abort_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL abort_count got=%0d want=4", count); end
    @(negedge clk); #1;
    checks++; if (abort !== 1'b0)    begin failures++; $display("FAIL abort_pulse got=%b want=0", abort); end
    checks++; if (gnt !== 4'b0001)   begin failures++; $display("FAIL abort_next_gnt got=%b want=0001", gnt); end
`else
    exp_q.push_back('{1, 11, 1'b1, 0});
`endif
    exp_q.push_back('{0, 3, 1'b1, 0});
    wait_obs(exp_q.size(), to);
    req = '0;
    checks++; if (to) begin failures++; $display("FAIL wd_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.w !== e.w || o.ok !== 1'b1) begin
        failures++; $display("FAIL wd_grant got=idx%0d w%0d ok%0d want=idx%0d w%0d", o.idx, o.w, o.ok, e.idx, e.w);
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_round_robin();
    test_late_arrival();
    test_reset_mid_run();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
